// File: rtl/vend_pkg.sv
// Shared types and constants for the newspaper vending slice: dispenser state
// encoding, coin denomination and system clock rate.
package vend_pkg;

   typedef enum logic [2:0] {
      IDLE,
      MOTOR,
      WAIT,
      EJECT,
      GAP,
      DONE,
      FAULT
   } state_e;

   localparam int COIN_VALUE = 5;
   localparam int CLK_HZ     = 100_000_000;

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr+1 (wrapping) and
// returns the first active requester as a one-hot winner.
module rr_arbiter #(
   parameter int N = 2,
   localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     winner,
   output logic             valid
);

   logic [PTR_W-1:0] idx;

   // NOTE: every output and temporary gets a default before the search loop;
   // a path that leaves any of them unassigned would infer a latch.
   always_comb begin
      winner = '0;
      valid  = 1'b0;
      idx    = '0;
      for (int k = 1; k <= N; k++) begin
         idx = PTR_W'((int'(ptr) + k) % N);
         if (!valid && req[idx]) begin
            winner[idx] = 1'b1;
            valid       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dispense_scheduler.sv
// Shares one newspaper dispenser between N_REQ vending FSMs: round-robin grant,
// motor pulse, paper-exit wait with timeout, 5-rupee change ejection, done.
module dispense_scheduler
   import vend_pkg::*;
#(
   parameter int N_REQ     = 2,
   parameter int AMT_W     = 5,
   parameter int MOTOR_CYC = 50_000_000,
   parameter int SENSE_TMO = 100_000_000,
   parameter int EJECT_CYC = 10_000_000,
   parameter int GAP_CYC   = 10_000_000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*AMT_W-1:0] change_amt,
   input  logic                   paper_sensor,
   input  logic                   fault_clr,
   output logic [N_REQ-1:0]       grant,
   output logic [N_REQ-1:0]       done,
   output logic                   motor_on,
   output logic                   coin_eject,
   output logic                   busy,
   output logic                   fault
);

   localparam int PTR_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_MAX   = max4(MOTOR_CYC, SENSE_TMO, EJECT_CYC, GAP_CYC);
   localparam int CNT_W     = $clog2(CNT_MAX + 1);
   localparam int MAX_COINS = ((1 << AMT_W) - 1) / COIN_VALUE;
   localparam int COIN_W    = $clog2(MAX_COINS + 1);

   state_e             state_q, state_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [COIN_W-1:0]  coins_q, coins_d;
   logic               seen_q, seen_d;
   logic [2:0]         sync_q, sync_d;
   logic [N_REQ-1:0]   grant_q, grant_d;
   logic [N_REQ-1:0]   done_q, done_d;
   logic               motor_on_q, motor_on_d;
   logic               coin_eject_q, coin_eject_d;
   logic               busy_q, busy_d;
   logic               fault_q, fault_d;

   logic [N_REQ-1:0]   arb_winner;
   logic               arb_valid;
   logic [PTR_W-1:0]   win_idx;
   logic [AMT_W-1:0]   win_amt;
   logic               sense_edge;

   rr_arbiter #(.N(N_REQ)) u_arb (
      .req    (req),
      .ptr    (ptr_q),
      .winner (arb_winner),
      .valid  (arb_valid)
   );

   always_comb begin
      win_idx = '0;
      win_amt = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (arb_winner[i]) begin
            win_idx = PTR_W'(i);
            win_amt = change_amt[i*AMT_W +: AMT_W];
         end
      end
   end

   // Two flops bring the sensor into the clock domain, the third gives the edge.
   assign sync_d     = {sync_q[1:0], paper_sensor};
   assign sense_edge = sync_q[1] & ~sync_q[2];

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      cnt_d        = cnt_q;
      coins_d      = coins_q;
      seen_d       = seen_q;
      grant_d      = grant_q;
      done_d       = '0;
      motor_on_d   = motor_on_q;
      coin_eject_d = coin_eject_q;
      busy_d       = busy_q;
      fault_d      = fault_q;

      case (state_q)
         IDLE: begin
            if (arb_valid) begin
               state_d    = MOTOR;
               ptr_d      = win_idx;
               grant_d    = arb_winner;
               motor_on_d = 1'b1;
               busy_d     = 1'b1;
               seen_d     = 1'b0;
               coins_d    = COIN_W'(int'(win_amt) / COIN_VALUE);
               cnt_d      = CNT_W'(MOTOR_CYC - 1);
            end
         end
         MOTOR: begin
            // Paper can leave while the motor is still running; remember it.
            if (sense_edge) seen_d = 1'b1;
            if (cnt_q == '0) begin
               state_d    = WAIT;
               motor_on_d = 1'b0;
               cnt_d      = CNT_W'(SENSE_TMO - 1);
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         WAIT: begin
            if (seen_q || sense_edge) begin
               if (coins_q != '0) begin
                  state_d      = EJECT;
                  coin_eject_d = 1'b1;
                  cnt_d        = CNT_W'(EJECT_CYC - 1);
               end else begin
                  state_d = DONE;
                  done_d  = grant_q;
               end
            end else if (cnt_q == '0) begin
               state_d = FAULT;
               grant_d = '0;
               fault_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         EJECT: begin
            if (cnt_q == '0) begin
               coins_d      = coins_q - 1'b1;
               coin_eject_d = 1'b0;
               if (coins_q != COIN_W'(1)) begin
                  state_d = GAP;
                  cnt_d   = CNT_W'(GAP_CYC - 1);
               end else begin
                  state_d = DONE;
                  done_d  = grant_q;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         GAP: begin
            if (cnt_q == '0) begin
               state_d      = EJECT;
               coin_eject_d = 1'b1;
               cnt_d        = CNT_W'(EJECT_CYC - 1);
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
         end
         FAULT: begin
            if (fault_clr) begin
               state_d = IDLE;
               fault_d = 1'b0;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d      = IDLE;
            grant_d      = '0;
            motor_on_d   = 1'b0;
            coin_eject_d = 1'b0;
            busy_d       = 1'b0;
            fault_d      = 1'b0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the values of the previous cycle regardless of statement order.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         ptr_q        <= PTR_W'(N_REQ - 1);
         cnt_q        <= '0;
         coins_q      <= '0;
         seen_q       <= 1'b0;
         sync_q       <= '0;
         grant_q      <= '0;
         done_q       <= '0;
         motor_on_q   <= 1'b0;
         coin_eject_q <= 1'b0;
         busy_q       <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         cnt_q        <= cnt_d;
         coins_q      <= coins_d;
         seen_q       <= seen_d;
         sync_q       <= sync_d;
         grant_q      <= grant_d;
         done_q       <= done_d;
         motor_on_q   <= motor_on_d;
         coin_eject_q <= coin_eject_d;
         busy_q       <= busy_d;
         fault_q      <= fault_d;
      end
   end

   assign grant      = grant_q;
   assign done       = done_q;
   assign motor_on   = motor_on_q;
   assign coin_eject = coin_eject_q;
   assign busy       = busy_q;
   assign fault      = fault_q;

endmodule
